layer_out_serializer: RTL and testbench

- Parametrised successor to the single-shot accumulator-to-buffer writer.
- Accepts a vector of NUM_CH parallel accumulator results and streams them one word per transfer into an on-chip result buffer, generating the addresses.
- Adds a ready/valid input handshake, write-side backpressure, a one-vector shadow register for back-to-back vectors, and a configurable base/stride address.
- Sits between the MAC array accumulators and the layer output / temp result RAM.

---
 rtl/layer_out_serializer.sv | 148 ++++++++++++++
 tb/tb_layer_out_serializer.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/layer_out_serializer.sv
// layer_out_serializer: streams an NUM_CH-word accumulator vector into the result buffer.
// Optional running argmax tracker enabled by defining SER_ARGMAX_EN.
module layer_out_serializer #(
    parameter int unsigned NUM_CH       = 10,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned ADDR_WIDTH   = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
    parameter logic [ADDR_WIDTH-1:0] ADDR_STRIDE = 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [NUM_CH*DATA_WIDTH-1:0] in_data,
    input  logic                         addr_clr,
    output logic                         wr_en,
    input  logic                         wr_ready,
    output logic [ADDR_WIDTH-1:0]        wr_addr,
    output logic [DATA_WIDTH-1:0]        wr_data,
    output logic                         vec_done,
    output logic                         busy,
    output logic [15:0]                  vec_cnt
`ifdef SER_ARGMAX_EN
    ,
    output logic [$clog2(NUM_CH)-1:0]    argmax_idx
`endif
);

    localparam int CW = $clog2(NUM_CH);

    typedef enum logic {
        IDLE,
        DRAIN
    } state_t;

    state_t                state;
    logic [DATA_WIDTH-1:0] in_words [NUM_CH];
    logic [DATA_WIDTH-1:0] active_q [NUM_CH];
    logic [DATA_WIDTH-1:0] shadow_q [NUM_CH];
    logic [CW-1:0]         ch;
    logic                  shadow_full;
    logic                  accept;
    logic                  xfer;
    logic                  last;

    // Channel 0 sits in the most significant slice of in_data.
    always_comb begin
        for (int c = 0; c < int'(NUM_CH); c++) begin
            in_words[c] = in_data[(int'(NUM_CH) - 1 - c) * int'(DATA_WIDTH) +: DATA_WIDTH];
        end
    end

    assign in_ready = !shadow_full;
    assign accept   = in_valid && in_ready;
    assign wr_en    = (state == DRAIN);
    assign xfer     = wr_en && wr_ready;
    assign last     = xfer && (ch == CW'(NUM_CH - 1));
    assign wr_data  = wr_en ? active_q[ch] : '0;
    assign busy     = wr_en || shadow_full;

    // Drain FSM: loads active/shadow vectors and walks the channel index.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            ch          <= '0;
            shadow_full <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        active_q <= in_words;
                        ch       <= '0;
                        state    <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (last) begin
                        ch <= '0;
                        if (shadow_full) begin
                            active_q    <= shadow_q;
                            shadow_full <= 1'b0;
                        end else if (accept) begin
                            active_q <= in_words;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        if (xfer) begin
                            ch <= ch + CW'(1);
                        end
                        if (accept) begin
                            shadow_q    <= in_words;
                            shadow_full <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Address generation, completion pulse and vector counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_addr  <= BASE_ADDR;
            vec_done <= 1'b0;
            vec_cnt  <= '0;
        end else begin
            vec_done <= last;
            if (last) begin
                vec_cnt <= vec_cnt + 16'd1;
            end
            if (addr_clr) begin
                wr_addr <= BASE_ADDR;
            end else if (xfer) begin
                wr_addr <= wr_addr + ADDR_STRIDE;
            end
        end
    end

`ifdef SER_ARGMAX_EN
    logic signed [DATA_WIDTH-1:0] max_val;
    logic signed [DATA_WIDTH-1:0] cur_val;
    logic [CW-1:0]                max_idx;
    logic                         take;

    assign cur_val = $signed(wr_data);
    assign take    = (ch == '0) || (cur_val > max_val);

    // Running signed maximum; strict compare keeps the lower index on ties.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            max_val    <= '0;
            max_idx    <= '0;
            argmax_idx <= '0;
        end else if (xfer) begin
            if (take) begin
                max_val <= cur_val;
                max_idx <= ch;
            end
            if (last) begin
                argmax_idx <= take ? ch : max_idx;
            end
        end
    end
`endif

endmodule

// File: tb/tb_layer_out_serializer.sv
// tb_layer_out_serializer: directed checks for layer_out_serializer.
// Instance uses BASE_ADDR=0x100, ADDR_STRIDE=4.
module tb_layer_out_serializer;

    localparam int NCH = 10;
    localparam int DW  = 32;
    localparam int AW  = 32;
    localparam logic [AW-1:0] BASE = 32'h100;
    localparam logic [AW-1:0] STRD = 32'd4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [NCH*DW-1:0] in_data = '0;
    logic              addr_clr = 1'b0;
    logic              wr_en;
    logic              wr_ready = 1'b0;
    logic [AW-1:0]     wr_addr;
    logic [DW-1:0]     wr_data;
    logic              vec_done;
    logic              busy;
    logic [15:0]       vec_cnt;
`ifdef SER_ARGMAX_EN
    logic [3:0]        argmax_idx;
`endif

    layer_out_serializer #(
        .NUM_CH(NCH),
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .BASE_ADDR(BASE),
        .ADDR_STRIDE(STRD)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_data(in_data),
        .addr_clr(addr_clr),
        .wr_en(wr_en),
        .wr_ready(wr_ready),
        .wr_addr(wr_addr),
        .wr_data(wr_data),
        .vec_done(vec_done),
        .busy(busy),
        .vec_cnt(vec_cnt)
`ifdef SER_ARGMAX_EN
        ,
        .argmax_idx(argmax_idx)
`endif
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got === exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Write/done log gathered on the falling edge.
    int            cyc = 0;
    logic [AW-1:0] wa_q [$];
    logic [DW-1:0] wd_q [$];
    int            wc_q [$];
    int            dc_q [$];
    int            am_q [$];
    bit            ready_dropped = 1'b0;
    bit            prev_stall = 1'b0;
    logic [AW-1:0] prev_addr;
    logic [DW-1:0] prev_data;
    bit            bp_en = 1'b0;
    int            bp_cnt = 0;

    always @(negedge clk) begin
        cyc++;
        if (rst_n) begin
            if (wr_en && wr_ready) begin
                wa_q.push_back(wr_addr);
                wd_q.push_back(wr_data);
                wc_q.push_back(cyc);
            end
            if (vec_done) begin
                dc_q.push_back(cyc);
`ifdef SER_ARGMAX_EN
                am_q.push_back(int'(argmax_idx));
`endif
            end
            if (!in_ready) ready_dropped = 1'b1;
            if (prev_stall && wr_en) begin
                chk("stall_addr", 64'(wr_addr), 64'(prev_addr));
                chk("stall_data", 64'(wr_data), 64'(prev_data));
            end
            prev_stall = wr_en && !wr_ready;
            prev_addr  = wr_addr;
            prev_data  = wr_data;
        end else begin
            prev_stall = 1'b0;
        end
    end

    // Backpressure pattern 1,0,0,1,0,0...
    always @(posedge clk) begin
        #1;
        if (bp_en) begin
            wr_ready = (bp_cnt % 3 == 0);
            bp_cnt++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_q();
        wa_q.delete();
        wd_q.delete();
        wc_q.delete();
        dc_q.delete();
        am_q.delete();
        ready_dropped = 1'b0;
    endtask

    function automatic logic [NCH*DW-1:0] pack_arr(input int w [NCH]);
        logic [NCH*DW-1:0] v;
        v = '0;
        for (int i = 0; i < NCH; i++) v[(NCH-1-i)*DW +: DW] = w[i];
        return v;
    endfunction

    function automatic logic [NCH*DW-1:0] pack(input int base);
        int w [NCH];
        for (int i = 0; i < NCH; i++) w[i] = base + i;
        return pack_arr(w);
    endfunction

    task automatic send(input logic [NCH*DW-1:0] v);
        logic r;
        in_valid = 1'b1;
        in_data  = v;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            r = in_ready;
            tick();
            if (r) begin
                in_valid = 1'b0;
                return;
            end
        end
        in_valid = 1'b0;
        chk("accept_timeout", 64'd0, 64'd1);
    endtask

    task automatic wait_wr(input int n);
        for (int i = 0; i < 400; i++) begin
            if (wa_q.size() >= n) return;
            @(negedge clk);
        end
        chk("write_timeout", 64'(wa_q.size()), 64'(n));
    endtask

    task automatic chk_wr(input string tag, input int k, input int data);
        chk({tag, "_addr"}, 64'(wa_q.size() > k ? wa_q[k] : 32'hDEAD_BEEF), 64'(BASE + STRD * k));
        chk({tag, "_data"}, 64'(wd_q.size() > k ? wd_q[k] : 32'hDEAD_BEEF), 64'(data));
    endtask

    function automatic int dc_at(input int k);
        return dc_q.size() > k ? dc_q[k] : -1;
    endfunction

    function automatic int wc_at(input int k);
        return wc_q.size() > k ? wc_q[k] : -100;
    endfunction

    initial begin
        int n;

        // Reset state
        repeat (3) tick();
        @(negedge clk);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_wr_en", 64'(wr_en), 64'd0);
        chk("rst_wr_addr", 64'(wr_addr), 64'(BASE));
        chk("rst_wr_data", 64'(wr_data), 64'd0);
        chk("rst_vec_done", 64'(vec_done), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_vec_cnt", 64'(vec_cnt), 64'd0);
`ifdef SER_ARGMAX_EN
        chk("rst_argmax", 64'(argmax_idx), 64'd0);
`endif
        tick();
        rst_n    = 1'b1;
        wr_ready = 1'b1;

        // Single vector
        clr_q();
        send(pack(32'h10));
        chk("t1_latency_wr_en", 64'(wr_en), 64'd1);
        wait_wr(10);
        repeat (3) tick();
        for (int k = 0; k < NCH; k++) chk_wr("t1", k, 32'h10 + k);
        chk("t1_contig", 64'(wc_at(9) - wc_at(0)), 64'd9);
        chk("t1_done_n", 64'(dc_q.size()), 64'd1);
        chk("t1_done_cyc", 64'(dc_at(0)), 64'(wc_at(9) + 1));
        chk("t1_vec_cnt", 64'(vec_cnt), 64'd1);
        chk("t1_ready_held", 64'(ready_dropped), 64'd0);
        chk("t1_busy_idle", 64'(busy), 64'd0);
        chk("t1_wr_en_idle", 64'(wr_en), 64'd0);
        chk("t1_data_idle", 64'(wr_data), 64'd0);

        // addr_clr
        chk("pre_clr_addr", 64'(wr_addr), 64'(BASE + STRD * 10));
        addr_clr = 1'b1;
        tick();
        addr_clr = 1'b0;
        chk("clr_addr", 64'(wr_addr), 64'(BASE));

        // Back-to-back, three vectors
        clr_q();
        send(pack(32'h20));
        send(pack(32'h30));
        send(pack(32'h40));
        wait_wr(30);
        repeat (3) tick();
        for (int k = 0; k < 3 * NCH; k++) chk_wr("b2b", k, 32'h20 + 32'h10 * (k / NCH) + k % NCH);
        chk("b2b_contig", 64'(wc_at(29) - wc_at(0)), 64'd29);
        chk("b2b_done_n", 64'(dc_q.size()), 64'd3);
        chk("b2b_done_gap1", 64'(dc_at(1) - dc_at(0)), 64'd10);
        chk("b2b_done_gap2", 64'(dc_at(2) - dc_at(1)), 64'd10);
        chk("b2b_done_cyc", 64'(dc_at(2)), 64'(wc_at(29) + 1));
        chk("b2b_ready_drop", 64'(ready_dropped), 64'd1);
        chk("b2b_vec_cnt", 64'(vec_cnt), 64'd4);

        // Backpressure
        addr_clr = 1'b1;
        tick();
        addr_clr = 1'b0;
        clr_q();
        bp_cnt = 0;
        bp_en  = 1'b1;
        send(pack(32'h50));
        wait_wr(10);
        repeat (12) tick();
        bp_en    = 1'b0;
        wr_ready = 1'b1;
        chk("bp_count", 64'(wa_q.size()), 64'd10);
        for (int k = 0; k < NCH; k++) chk_wr("bp", k, 32'h50 + k);
        chk("bp_done_n", 64'(dc_q.size()), 64'd1);
        chk("bp_vec_cnt", 64'(vec_cnt), 64'd5);

        // Reset mid-drain
        addr_clr = 1'b1;
        tick();
        addr_clr = 1'b0;
        clr_q();
        send(pack(32'h60));
        wait_wr(5);
        tick();
        rst_n = 1'b0;
        tick();
        chk("mrst_wr_en", 64'(wr_en), 64'd0);
        chk("mrst_wr_addr", 64'(wr_addr), 64'(BASE));
        chk("mrst_busy", 64'(busy), 64'd0);
        chk("mrst_vec_cnt", 64'(vec_cnt), 64'd0);
        chk("mrst_in_ready", 64'(in_ready), 64'd1);
        rst_n = 1'b1;
        n = wa_q.size();
        repeat (5) tick();
        chk("mrst_no_writes", 64'(wa_q.size()), 64'(n));
        clr_q();
        send(pack(32'h70));
        wait_wr(10);
        repeat (3) tick();
        for (int k = 0; k < NCH; k++) chk_wr("post_rst", k, 32'h70 + k);
        chk("post_rst_vec_cnt", 64'(vec_cnt), 64'd1);

`ifdef SER_ARGMAX_EN
        // Argmax: tie keeps lower index, all-negative max at last channel
        addr_clr = 1'b1;
        tick();
        addr_clr = 1'b0;
        clr_q();
        send(pack_arr('{-5, 7, 3, 7, -1, 0, 2, 1, 6, 4}));
        send(pack_arr('{-100, -90, -80, -70, -60, -50, -40, -30, -20, -3}));
        wait_wr(20);
        repeat (3) tick();
        chk("am_done_n", 64'(am_q.size()), 64'd2);
        chk("am_tie", 64'(am_q.size() > 0 ? am_q[0] : -1), 64'd1);
        chk("am_neg", 64'(am_q.size() > 1 ? am_q[1] : -1), 64'd9);
        chk("am_hold", 64'(argmax_idx), 64'd9);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
